// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage IEEE-754 adder/subtractor, RNE rounding.
// clk/rst_n, in_valid/in_ready/in_a/in_b/in_sub -> out_valid/out_ready/out_sum/out_flags.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_sum,
  output logic [3:0]               out_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int XW  = MAN_W + 4;
  localparam int LZW = $clog2(MAN_W + 5);
  localparam int EW  = EXP_W + 2;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack, classify, align
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  assign sa = in_a[W-1];
  assign ea = in_a[W-2:MAN_W];
  assign fa = in_a[MAN_W-1:0];
  assign sb = in_b[W-1] ^ in_sub;
  assign eb = in_b[W-2:MAN_W];
  assign fb = in_b[MAN_W-1:0];

  // Subnormals count as zero: only the exponent is inspected.
  assign a_zero = (ea == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_zero = (eb == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign b_snan = b_nan && !fb[MAN_W-1];

  logic         spec;
  logic [W-1:0] spec_val;
  logic [3:0]   spec_flags;

  always_comb begin
    spec       = 1'b1;
    spec_val   = '0;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_val   = QNAN;
      spec_flags = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_val   = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_val = {sa, ea, fa};
    end else if (b_inf) begin
      spec_val = {sb, eb, fb};
    end else if (a_zero && b_zero) begin
      // Only -0 + -0 keeps the negative sign under RNE.
      spec_val = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_val = {sb, eb, fb};
    end else if (b_zero) begin
      spec_val = {sa, ea, fa};
    end else begin
      spec = 1'b0;
    end
  end

  logic             swap, sx;
  logic [EXP_W-1:0] ex, ey, dexp;
  logic [MAN_W-1:0] fx, fy;
  logic [LZW-1:0]   sh;
  logic [2*XW-1:0]  y_wide;
  logic [XW-1:0]    x_ext, y_al;

  assign swap = {eb, fb} > {ea, fa};
  assign sx   = swap ? sb : sa;
  assign ex   = swap ? eb : ea;
  assign fx   = swap ? fb : fa;
  assign ey   = swap ? ea : eb;
  assign fy   = swap ? fa : fb;
  assign dexp = ex - ey;

  // Shifts of XW or more push everything into the sticky bit.
  assign sh = (dexp > EXP_W'(XW)) ? LZW'(XW) : LZW'(dexp);
  assign y_wide = {1'b1, fy, 3'b000, {XW{1'b0}}} >> sh;
  assign y_al   = {y_wide[2*XW-1:XW+1],
                   y_wide[XW] | (|y_wide[XW-1:0])};
  assign x_ext  = {1'b1, fx, 3'b000};

  logic             s1_valid, s1_spec, s1_sign, s1_sub;
  logic [W-1:0]     s1_spec_val;
  logic [3:0]       s1_spec_flags;
  logic [EXP_W-1:0] s1_exp;
  logic [XW-1:0]    s1_x, s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_spec       <= 1'b0;
      s1_spec_val   <= '0;
      s1_spec_flags <= '0;
      s1_sign       <= 1'b0;
      s1_sub        <= 1'b0;
      s1_exp        <= '0;
      s1_x          <= '0;
      s1_y          <= '0;
    end else if (en) begin
      s1_valid      <= in_valid;
      s1_spec       <= spec;
      s1_spec_val   <= spec_val;
      s1_spec_flags <= spec_flags;
      s1_sign       <= sx;
      s1_sub        <= sa ^ sb;
      s1_exp        <= ex;
      s1_x          <= x_ext;
      s1_y          <= y_al;
    end
  end

  // ---------------- S2: add / subtract magnitudes
  logic [XW:0] sum;
  assign sum = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y})
                      : ({1'b0, s1_x} + {1'b0, s1_y});

  logic             s2_valid, s2_spec, s2_sign;
  logic [W-1:0]     s2_spec_val;
  logic [3:0]       s2_spec_flags;
  logic [EXP_W-1:0] s2_exp;
  logic [XW:0]      s2_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid      <= 1'b0;
      s2_spec       <= 1'b0;
      s2_spec_val   <= '0;
      s2_spec_flags <= '0;
      s2_sign       <= 1'b0;
      s2_exp        <= '0;
      s2_sum        <= '0;
    end else if (en) begin
      s2_valid      <= s1_valid;
      s2_spec       <= s1_spec;
      s2_spec_val   <= s1_spec_val;
      s2_spec_flags <= s1_spec_flags;
      s2_sign       <= s1_sign;
      s2_exp        <= s1_exp;
      s2_sum        <= sum;
    end
  end

  // ---------------- S3: normalise, round, pack
  logic           carry, found;
  logic [LZW-1:0] lz;

  assign carry = s2_sum[XW];

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found && s2_sum[i]) begin
        lz    = LZW'(XW - 1 - i);
        found = 1'b1;
      end
    end
  end

  // norm drops the hidden bit: {frac, G, R, S}.
  logic [XW-2:0]    norm, shl;
  logic [EW-1:0]    e_u, e_r;
  logic             g, r, st, lsb, inc, rc;
  logic [MAN_W-1:0] frac_r;

  assign shl  = s2_sum[XW-2:0] << lz;
  assign norm = carry ? {s2_sum[XW-1:2], s2_sum[1] | s2_sum[0]}
                      : shl;
  assign e_u  = {2'b00, s2_exp} + EW'(carry) - EW'(lz);
  assign lsb  = norm[3];
  assign g    = norm[2];
  assign r    = norm[1];
  assign st   = norm[0];
  assign inc  = g & (r | st | lsb);
  // A carry out of the fraction means the mantissa rounded to 10.0.
  assign {rc, frac_r} = {1'b0, norm[XW-2:3]} + (MAN_W+1)'(inc);
  assign e_r  = e_u + EW'(rc);

  logic [W-1:0] res;
  logic [3:0]   res_flags;

  always_comb begin
    res       = '0;
    res_flags = '0;
    if (s2_spec) begin
      res       = s2_spec_val;
      res_flags = s2_spec_flags;
    end else if (s2_sum == '0) begin
      res = '0;
    end else if (e_u[EW-1] || (e_u == '0)) begin
      res       = {s2_sign, {(W-1){1'b0}}};
      res_flags = 4'b0011;
    end else if (e_r >= EMAX) begin
      res       = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else begin
      res       = {s2_sign, e_r[EXP_W-1:0], frac_r};
      res_flags = {3'b000, g | r | st};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sum   <= res;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed-vector bench for fp_add_pipe (binary32).
// One task per scenario, each with inline comparisons.
module tb_fp_add_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;

  int total = 0;
  int bad   = 0;

  fp_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op with out_ready=1; lat counts cycles from the
  // accept cycle (1) until out_valid is seen.
  task automatic do_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s,
    output logic [3:0]  f,
    output int          lat
  );
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = out_sum;
    f = out_flags;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    total++;
    if (out_sum !== 32'h0) begin
      bad++;
      $display("FAIL reset_sum: got %h want 0", out_sum);
    end
    total++;
    if (out_flags !== 4'h0) begin
      bad++;
      $display("FAIL reset_flags: got %h want 0", out_flags);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] s;
    logic [3:0]  f;
    int          l;
    do_op(32'h3F800000, 32'h40000000, 1'b0, s, f, l);
    total++;
    if (l != 3) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 3", l);
    end
    total++;
    if (s !== 32'h40400000) begin
      bad++;
      $display("FAIL basic_sum: got %h want 40400000", s);
    end
    total++;
    if (f !== 4'h0) begin
      bad++;
      $display("FAIL basic_flags: got %h want 0", f);
    end
  endtask

  task automatic test_zero;
    logic [31:0] s;
    logic [3:0]  f;
    int          l;
    do_op(32'h40400000, 32'h40400000, 1'b1, s, f, l);
    total++;
    if (s !== 32'h0 || f !== 4'h0) begin
      bad++;
      $display("FAIL x_minus_x: got %h/%h want 00000000/0", s, f);
    end
    do_op(32'h80000000, 32'h80000000, 1'b0, s, f, l);
    total++;
    if (s !== 32'h80000000 || f !== 4'h0) begin
      bad++;
      $display("FAIL negzero: got %h/%h want 80000000/0", s, f);
    end
  endtask

  task automatic test_round;
    logic [31:0] s;
    logic [3:0]  f;
    int          l;
    do_op(32'h3F800000, 32'h33800000, 1'b0, s, f, l);
    total++;
    if (s !== 32'h3F800000 || f !== 4'h1) begin
      bad++;
      $display("FAIL tie_even: got %h/%h want 3f800000/1", s, f);
    end
    do_op(32'h3F800001, 32'h33800000, 1'b0, s, f, l);
    total++;
    if (s !== 32'h3F800002 || f !== 4'h1) begin
      bad++;
      $display("FAIL tie_odd: got %h/%h want 3f800002/1", s, f);
    end
  endtask

  task automatic test_special;
    logic [31:0] va [13] = '{
      32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'h7FC00000,
      32'h7F800000, 32'h00000000, 32'h00000001, 32'h00800001,
      32'h00800000, 32'h3F800000, 32'h3FC00000, 32'hBF800000,
      32'h7F800000};
    logic [31:0] vb [13] = '{
      32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h3F800000,
      32'h3F800000, 32'h40000000, 32'h3F800000, 32'h00800000,
      32'h00800001, 32'h00800000, 32'h3FA00000, 32'h40000000,
      32'h7F800000};
    logic        vsub [13] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] vs [13] = '{
      32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
      32'h7F800000, 32'hC0000000, 32'h3F800000, 32'h00000000,
      32'h80000000, 32'h3F800000, 32'h3E800000, 32'h3F800000,
      32'h7FC00000};
    logic [3:0]  vf [13] = '{
      4'h5, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0,
      4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 4'h8};
    logic [31:0] s;
    logic [3:0]  f;
    int          l;
    for (int i = 0; i < 13; i++) begin
      do_op(va[i], vb[i], vsub[i], s, f, l);
      total++;
      if (s !== vs[i] || f !== vf[i]) begin
        bad++;
        $display("FAIL special_%0d: got %h/%h want %h/%h",
                 i, s, f, vs[i], vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ain [6] = '{
      32'h3F800000, 32'h40000000, 32'h40400000,
      32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] exp_s [6] = '{
      32'h40000000, 32'h40400000, 32'h40800000,
      32'h40A00000, 32'h40C00000, 32'h40E00000};
    int          got;
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int guard;
          @(negedge clk);
          in_a     = ain[i];
          in_b     = 32'h3F800000;
          in_sub   = 1'b0;
          in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
          end
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        logic        stalled;
        logic [31:0] held;
        int          cyc;
        stalled = 1'b0;
        cyc = 0;
        @(posedge clk);
        #1;
        while (got < 6 && cyc < 200) begin
          if (out_valid && !stalled) begin
            out_ready = 1'b0;
            held = out_sum;
            stalled = 1'b1;
            for (int k = 0; k < 4; k++) begin
              @(posedge clk);
              #1;
              total++;
              if (out_sum !== held || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold_%0d: got %h want %h",
                         k, out_sum, held);
              end
              total++;
              if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready_%0d: got %b want 0",
                         k, in_ready);
              end
            end
            out_ready = 1'b1;
          end
          if (out_valid && out_ready) begin
            total++;
            if (out_sum !== exp_s[got]) begin
              bad++;
              $display("FAIL b2b_%0d: got %h want %h",
                       got, out_sum, exp_s[got]);
            end
            got++;
          end
          @(posedge clk);
          #1;
          cyc++;
        end
      end
    join
    total++;
    if (got != 6) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 6", got);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_flight;
    logic [31:0] s;
    logic [3:0]  f;
    int          l;
    int          ghost;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a     = 32'h3F800000;
      in_b     = 32'h3F800000;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got %b want 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_hold: got %b want 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ghost = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) ghost++;
    end
    total++;
    if (ghost != 0) begin
      bad++;
      $display("FAIL rst_ghost: got %0d want 0", ghost);
    end
    do_op(32'h3F800000, 32'h40000000, 1'b0, s, f, l);
    total++;
    if (s !== 32'h40400000 || l != 3) begin
      bad++;
      $display("FAIL rst_after: got %h lat %0d want 40400000 lat 3",
               s, l);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_round();
    test_special();
    test_back_to_back();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
